// File: rtl/alu_disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : alu_disp_pkg                                           |
// | Description : Shared types and constants for the ALU result          |
// |               binary-to-BCD display stage: FSM state encoding,       |
// |               digit width, default sizing, add-3 correction rule     |
// |               and the sizing check helper.                           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package alu_disp_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_DIGITS     = 5;
    // Digits at or above this value are corrected before each shift.
    localparam int ADD3_THRESHOLD = 5;
    localparam int ADD3_VALUE     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True when DIGITS decimal digits can represent every DATA_W-bit value,
    // i.e. 10^digits > 2^data_w. Valid for data_w up to 62.
    function automatic bit digits_cover_width(input int data_w, input int digits);
        longint p10;
        longint p2;
        p10 = 1;
        for (int i = 0; i < digits; i++) begin
            if (p10 < 64'sd1000000000000000000) begin
                p10 = p10 * 10;
            end
        end
        p2 = longint'(1) << data_w;
        return (p10 > p2);
    endfunction

endpackage : alu_disp_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_digit_adj                                          |
// | Description : Combinational double-dabble digit correction: a BCD    |
// |               digit of 5 or more gets +3 so that the following left  |
// |               shift carries correctly into the next decimal digit.   |
// | Ports       : digit_in  - 4-bit BCD digit before correction          |
// |               digit_out - 4-bit corrected digit                      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module bcd_digit_adj
    import alu_disp_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // Input never exceeds 9, so the sum never exceeds 12 and fits in 4 bits.
    assign digit_out = (digit_in >= BCD_DIGIT_W'(ADD3_THRESHOLD))
                     ? digit_in + BCD_DIGIT_W'(ADD3_VALUE)
                     : digit_in;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/alu_result_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_result_bcd                                         |
// | Description : Accepts a DATA_W-bit unsigned ALU result over a        |
// |               valid/ready handshake, converts it to packed BCD with  |
// |               a one-bit-per-clock shift-add-3 engine and presents    |
// |               DIGITS decimal digits over a second handshake.         |
// | Ports       : clk, rst_n (async, active-low)                         |
// |               in_valid/in_ready/in_data  - binary input handshake    |
// |               out_valid/out_ready/bcd    - BCD output handshake      |
// |               blank                      - leading-zero mask         |
// |                                            (BCD_BLANK_LEADING_ZERO_EN)|
// |               busy                       - conversion in progress    |
// | Options     : `define BCD_BLANK_LEADING_ZERO_EN adds the blank port  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module alu_result_bcd
    import alu_disp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
`ifdef BCD_BLANK_LEADING_ZERO_EN
    output logic [DIGITS-1:0]             blank,
`endif
    output logic                          busy
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    if (!digits_cover_width(DATA_W, DIGITS)) begin : g_size_check
        $error("alu_result_bcd: DIGITS too small for DATA_W");
    end

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    sr_q,    sr_d;
    logic [ACC_W-1:0]     acc_q,   acc_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [ACC_W-1:0]     bcd_q,   bcd_d;

    logic [ACC_W-1:0]        acc_adj;
    logic [ACC_W+DATA_W-1:0] shift_w;
    logic [ACC_W-1:0]        acc_shift;
    logic [DATA_W-1:0]       sr_shift;
    logic                    last_shift;

    // Per-digit add-3 correction of the current accumulator.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
        bcd_digit_adj u_adj (
            .digit_in  (acc_q  [gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (acc_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected accumulator and data shift as one wide register; the data
    // MSB falls into the units digit LSB.
    assign shift_w    = {acc_adj, sr_q} << 1;
    assign acc_shift  = shift_w[ACC_W+DATA_W-1:DATA_W];
    assign sr_shift   = shift_w[DATA_W-1:0];
    assign last_shift = (cnt_q == CNT_W'(DATA_W - 1));

`ifdef BCD_BLANK_LEADING_ZERO_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_w;

    // blank[i] set when digit i and everything above it is zero; the units
    // digit is never blanked so a zero result still shows "0".
    always_comb begin
        logic zero_above;
        blank_w    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (acc_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_w[i] = zero_above;
        end
    end

    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
`endif

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
`ifdef BCD_BLANK_LEADING_ZERO_EN
            blank_q <= BLANK_RST;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
`ifdef BCD_BLANK_LEADING_ZERO_EN
            blank_q <= blank_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
`ifdef BCD_BLANK_LEADING_ZERO_EN
        blank_d = blank_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d    = in_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = sr_shift;
                acc_d = acc_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    // bcd only loads here so the display never sees partial sums.
                    bcd_d   = acc_shift;
`ifdef BCD_BLANK_LEADING_ZERO_EN
                    blank_d = blank_w;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q == ST_SHIFT);
        out_valid = (state_q == ST_DONE);
    end

    assign bcd = bcd_q;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    assign blank = blank_q;
`endif

endmodule : alu_result_bcd
`default_nettype wire

// File: tb/tb_alu_result_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_result_bcd                                      |
// | Description : Self-checking bench for alu_result_bcd: directed and   |
// |               random conversions compared with a decimal reference   |
// |               model, plus backpressure, async reset and streaming.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_alu_result_bcd;

    localparam int DATA_W = 16;
    localparam int DIGITS = 5;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    logic [DIGITS-1:0]     blank;
`endif

    int n_total = 0;
    int n_bad   = 0;

    alu_result_bcd #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
`ifdef BCD_BLANK_LEADING_ZERO_EN
        .blank     (blank),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by integer division.
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] ref_blank(input int unsigned v);
        logic [DIGITS-1:0] b;
        int unsigned p;
        b = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    logic [4*DIGITS-1:0] last_bcd;

    // Full conversion: accept, wait for result, stall `stall` cycles, drain.
    task automatic do_conv(input logic [DATA_W-1:0] v, input int stall);
        int n;
        logic [4*DIGITS-1:0] held;
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("bcd_hold_in_shift", 32'(bcd), 32'(last_bcd));
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, DATA_W);
        chk("bcd_value", 32'(bcd), 32'(ref_bcd(32'(v))));
        chk("in_ready_done", 32'(in_ready), 32'd0);
`ifdef BCD_BLANK_LEADING_ZERO_EN
        chk("blank_value", 32'(blank), 32'(ref_blank(32'(v))));
`endif
        held = bcd;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = ~v;
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_bcd", 32'(bcd), 32'(held));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        last_bcd = ref_bcd(32'(v));
    endtask

    initial begin
        int n_acc, n_out, cyc;
        int acc_cyc [2];
        logic [4*DIGITS-1:0] got [2];
        logic a_hs, o_hs;
        logic [4*DIGITS-1:0] snap;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        last_bcd  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
`ifdef BCD_BLANK_LEADING_ZERO_EN
        chk("rst_blank", 32'(blank), 32'h1E);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed values, including boundaries and a 10-cycle stall.
        do_conv(16'h0000, 0);
        do_conv(16'hFFFF, 2);
        do_conv(16'hFE01, 10);
        do_conv(16'h0001, 1);

        // Reset in the middle of a conversion.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bcd", 32'(bcd), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        last_bcd = '0;
        do_conv(16'h1234, 0);

        // Random values with random stalls.
        for (int k = 0; k < 20; k++) begin
            do_conv(DATA_W'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
        end

        // Back-to-back streaming with in_valid and out_ready held high.
        in_valid  = 1'b1;
        in_data   = 16'h0007;
        out_ready = 1'b1;
        n_acc = 0;
        n_out = 0;
        cyc   = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        got[0] = '0;
        got[1] = '0;
        while (n_out < 2 && cyc < 200) begin
            a_hs = in_valid && in_ready;
            o_hs = out_valid && out_ready;
            snap = bcd;
            @(posedge clk); #1;
            cyc++;
            if (a_hs) begin
                if (n_acc < 2) acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) in_data = 16'h0100;
                else            in_valid = 1'b0;
            end
            if (o_hs) begin
                if (n_out < 2) got[n_out] = snap;
                n_out++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_outputs", n_out, 2);
        chk("b2b_accepts", n_acc, 2);
        chk("b2b_first", 32'(got[0]), 32'h00007);
        chk("b2b_second", 32'(got[1]), 32'h00256);
        chk("b2b_period", acc_cyc[1] - acc_cyc[0], DATA_W + 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_alu_result_bcd
`default_nettype wire
